// File: rtl/detector_window_reader_pkg.sv
// Shared types and helpers for the windowed strip hit detector.
// DETECTOR_TIMESTAMP_EN widens the event record with a latched trigger timestamp.
package detector_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLDOFF} state_e;

  // Upper bound on a group slice handed to group_or; narrower slices are zero-extended.
  localparam int GROUP_MAX = 256;

`ifdef DETECTOR_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  function automatic int ngroups(input int din_w, input int grp_w);
    return din_w / grp_w;
  endfunction

  function automatic int tdata_width(input int din_w, input int ts_w);
    return din_w + (TS_ON ? ts_w : 0);
  endfunction

  function automatic logic group_or(input logic [GROUP_MAX-1:0] slice);
    return |slice;
  endfunction

endpackage

// File: rtl/detector_window_reader_if.sv
// AXI4-Stream style channel carrying detector event records.
interface detector_window_reader_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/detector_window_reader_event_reg.sv
// One-entry output register: loads a record when the slot is free or being drained,
// otherwise drops it and bumps a saturating drop counter.
module detector_event_reg #(
  parameter int DATA_W = 64,
  parameter int DROP_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic [DROP_W-1:0] drops_o
);
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic [DROP_W-1:0] drops_q, drops_d;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      drops_q  <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      drops_q  <= drops_d;
    end
  end

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    drops_d  = drops_q;
    if (tvalid_q && tready_i) tvalid_d = 1'b0;
    if (load_i) begin
      if (!tvalid_q || tready_i) begin
        tvalid_d = 1'b1;
        tdata_d  = load_data_i;
      end else if (drops_q != '1) begin
        drops_d = drops_q + DROP_W'(1);
      end
    end
  end

  assign tdata_o  = tdata_q;
  assign tvalid_o = tvalid_q;
  assign drops_o  = drops_q;
endmodule

// File: rtl/detector_window_reader.sv
// Windowed hit detector: masked trigger opens a window, din is OR-accumulated and emitted.
// Optional DETECTOR_TIMESTAMP_EN prepends the trigger-sample timestamp to each record.
module detector_window_reader
  import detector_pkg::*;
#(
  parameter int DIN_WIDTH   = 64,
  parameter int GROUP_WIDTH = 16,
  parameter int CNTR_WIDTH  = 8,
  parameter int TS_WIDTH    = 32,
  localparam int NGROUPS    = ngroups(DIN_WIDTH, GROUP_WIDTH),
  localparam int TDATA_W    = tdata_width(DIN_WIDTH, TS_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DIN_WIDTH-1:0]  din_i,
  input  logic [CNTR_WIDTH-1:0] cfg_window_i,
  input  logic [CNTR_WIDTH-1:0] cfg_holdoff_i,
  input  logic [NGROUPS-1:0]    cfg_mask_i,
  output logic [NGROUPS-1:0]    test_o,
  detector_window_reader_if.master m_axis,
  output logic [31:0]           sts_drops_o
);
  localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DIN_WIDTH-1:0]  data_q, data_d;
  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
  logic [NGROUPS-1:0]    grp_hit;
  logic                  trig;
  logic                  load;
  logic [DIN_WIDTH-1:0]  rec_data;
  logic [TDATA_W-1:0]    load_data;

  genvar gi;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_group
      assign grp_hit[gi] = cfg_mask_i[gi] &
                           group_or(GROUP_MAX'(din_i[gi*GROUP_WIDTH +: GROUP_WIDTH]));
      assign test_o[gi]  = group_or(GROUP_MAX'(data_q[gi*GROUP_WIDTH +: GROUP_WIDTH]));
    end
  endgenerate

  assign trig     = |grp_hit;
  assign rec_data = data_q | din_i;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      cntr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cntr_q  <= cntr_d;
    end
  end

  // Window compare is live against cfg_window_i, so lowering it mid-window closes early.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cntr_d  = cntr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = din_i;
        cntr_d = '0;
        if (trig) state_d = ACCUM;
      end
      ACCUM: begin
        data_d = data_q | din_i;
        cntr_d = cntr_q + CNTR_ONE;
        if (cntr_q >= cfg_window_i) begin
          load    = 1'b1;
          cntr_d  = '0;
          state_d = (cfg_holdoff_i != '0) ? HOLDOFF : IDLE;
        end
      end
      HOLDOFF: begin
        cntr_d = cntr_q + CNTR_ONE;
        if (cntr_q >= cfg_holdoff_i - CNTR_ONE) begin
          cntr_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DETECTOR_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_lat_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ts_cnt_q <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
      if (state_q == IDLE && trig) ts_lat_q <= ts_cnt_q;
    end
  end

  assign load_data = {ts_lat_q, rec_data};
`else
  assign load_data = rec_data;
`endif

  detector_event_reg #(
    .DATA_W (TDATA_W),
    .DROP_W (32)
  ) u_event_reg (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .load_i      (load),
    .load_data_i (load_data),
    .tdata_o     (m_axis.tdata),
    .tvalid_o    (m_axis.tvalid),
    .tready_i    (m_axis.tready),
    .drops_o     (sts_drops_o)
  );
endmodule

// File: tb/tb_detector_window_reader.sv
// Directed scenarios plus randomized traffic against a sample-counting reference model.
module tb_detector_window_reader;
  import detector_pkg::*;

  localparam int DW  = 64;
  localparam int GW  = 16;
  localparam int NG  = 4;
  localparam int CW  = 8;
  localparam int TW  = 32;
  localparam int TDW = tdata_width(DW, TW);

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [DW-1:0]  din = '0;
  logic [CW-1:0]  cfg_window = '0;
  logic [CW-1:0]  cfg_holdoff = '0;
  logic [NG-1:0]  cfg_mask = '1;
  logic           tready = 1'b1;
  logic [NG-1:0]  test;
  logic [31:0]    sts_drops;

  detector_window_reader_if #(.DATA_W(TDW)) axis_if ();
  assign axis_if.tready = tready;

  detector_window_reader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .din_i         (din),
    .cfg_window_i  (cfg_window),
    .cfg_holdoff_i (cfg_holdoff),
    .cfg_mask_i    (cfg_mask),
    .test_o        (test),
    .m_axis        (axis_if),
    .sts_drops_o   (sts_drops)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Reference model: counts samples taken in the window rather than tracking a counter.
  int              mode;        // 0 waiting, 1 in window, 2 holding off
  int              taken;
  int              hold_left;
  logic [DW-1:0]   acc;
  logic            m_tv;
  logic [TDW-1:0]  m_td;
  longint unsigned m_drops;
`ifdef DETECTOR_TIMESTAMP_EN
  logic [TW-1:0]   m_ts;
  logic [TW-1:0]   m_ts_lat;
`endif

  logic            dut_tv_s = 1'b0;
  logic [TDW-1:0]  dut_td_s = '0;
  logic [TDW-1:0]  rec_q[$];
  int              n_rec = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic masked_hit(input logic [DW-1:0] d, input logic [NG-1:0] m);
    logic h = 1'b0;
    for (int g = 0; g < NG; g++)
      if (m[g] && (d[g*GW +: GW] != '0)) h = 1'b1;
    return h;
  endfunction

  task automatic model_edge();
    logic           load = 1'b0;
    logic [TDW-1:0] rec = '0;
    logic           hs;
    if (!aresetn) begin
      mode = 0; taken = 0; hold_left = 0; acc = '0;
      m_tv = 1'b0; m_td = '0; m_drops = 0;
`ifdef DETECTOR_TIMESTAMP_EN
      m_ts = '0; m_ts_lat = '0;
`endif
      return;
    end
    hs = m_tv && tready;
    case (mode)
      0: begin
        acc = din;
        if (masked_hit(din, cfg_mask)) begin
          mode  = 1;
          taken = 1;
`ifdef DETECTOR_TIMESTAMP_EN
          m_ts_lat = m_ts;
`endif
        end
      end
      1: begin
        acc   = acc | din;
        taken = taken + 1;
        if (taken >= int'(cfg_window) + 2) begin
          load = 1'b1;
`ifdef DETECTOR_TIMESTAMP_EN
          rec = {m_ts_lat, acc};
`else
          rec = acc;
`endif
          if (cfg_holdoff == 0) mode = 0;
          else begin
            mode      = 2;
            hold_left = int'(cfg_holdoff);
          end
        end
      end
      default: begin
        hold_left = hold_left - 1;
        if (hold_left == 0) mode = 0;
      end
    endcase
    if (load) begin
      if (!m_tv || tready) begin
        m_tv = 1'b1;
        m_td = rec;
      end else if (m_drops < 64'hFFFF_FFFF) begin
        m_drops++;
      end
    end else if (hs) begin
      m_tv = 1'b0;
    end
`ifdef DETECTOR_TIMESTAMP_EN
    m_ts = m_ts + 1;
`endif
  endtask

  task automatic step(input logic [DW-1:0] d);
    logic [NG-1:0] exp_t;
    din = d;
    @(posedge aclk);
    if (aresetn && dut_tv_s && tready) begin
      rec_q.push_back(dut_td_s);
      n_rec++;
      $display("record %0d: tdata=%0h drops=%0d", n_rec, dut_td_s, sts_drops);
    end
    model_edge();
    #1;
    for (int g = 0; g < NG; g++) exp_t[g] = |acc[g*GW +: GW];
    chk("tvalid", axis_if.tvalid, m_tv);
    chk("tdata", axis_if.tdata, m_td);
    chk("test", test, exp_t);
    chk("drops", sts_drops, m_drops);
    dut_tv_s = axis_if.tvalid;
    dut_td_s = axis_if.tdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
  endtask

  function automatic logic [DW-1:0] bitv(input int b);
    logic [DW-1:0] v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] d;
    int r;

    // Reset state and single window with two hits
    cfg_window = 8'd3; cfg_holdoff = 8'd0; cfg_mask = 4'hF; tready = 1'b1;
    do_reset();
    chk("rst_test", test, 4'b0000);
    rec_q.delete();
    step(bitv(0)); idle(3); step(bitv(63));
    chk("t1_test", test, 4'b1001);
    idle(3);
    chk("t1_count", rec_q.size(), 1);
    if (rec_q.size() > 0) chk("t1_rec", rec_q[0][DW-1:0], 64'h8000_0000_0000_0001);

    // Mask blocks group 1, group 0 triggers
    cfg_mask = 4'b0001; rec_q.delete();
    step(bitv(20)); idle(7);
    chk("t2_none", rec_q.size(), 0);
    step(bitv(3)); idle(8);
    chk("t2_count", rec_q.size(), 1);
    if (rec_q.size() > 0) chk("t2_rec", rec_q[0][DW-1:0], bitv(3));

    // Back-pressure drops
    cfg_mask = 4'hF; cfg_window = 8'd0; tready = 1'b0; rec_q.delete();
    step(bitv(0)); idle(3); step(bitv(1)); idle(3); step(bitv(2)); idle(3);
    chk("t3_drops", sts_drops, 2);
    tready = 1'b1;
    idle(3);
    chk("t3_count", rec_q.size(), 1);
    if (rec_q.size() > 0) chk("t3_rec", rec_q[0][DW-1:0], bitv(0));

    // Hold-off ignores triggers
    cfg_holdoff = 8'd5; rec_q.delete();
    step(bitv(4)); step('0); step('0); step(bitv(5)); idle(3);
    step(bitv(6)); idle(8);
    chk("t4_count", rec_q.size(), 2);
    if (rec_q.size() > 1) chk("t4_rec", rec_q[1][DW-1:0], bitv(6));

    // Reset in the middle of a window
    cfg_window = 8'd3; cfg_holdoff = 8'd0; rec_q.delete();
    step(bitv(7)); step('0);
    aresetn = 1'b0; step('0);
    chk("t5_tvalid", axis_if.tvalid, 1'b0);
    chk("t5_drops", sts_drops, 0);
    aresetn = 1'b1; idle(8);
    chk("t5_none", rec_q.size(), 0);
    step(bitv(8)); idle(8);
    chk("t5_count", rec_q.size(), 1);
    if (rec_q.size() > 0) chk("t5_rec", rec_q[0][DW-1:0], bitv(8));

`ifdef DETECTOR_TIMESTAMP_EN
    // Timestamps at trigger samples
    cfg_window = 8'd0; do_reset(); rec_q.delete();
    while (m_ts < 100) step('0);
    step(bitv(9)); idle(4);
    while (m_ts < 250) step('0);
    step(bitv(10)); idle(4);
    chk("t6_count", rec_q.size(), 2);
    if (rec_q.size() > 1) begin
      chk("t6_ts0", rec_q[0][TDW-1:DW], 100);
      chk("t6_ts1", rec_q[1][TDW-1:DW], 250);
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (mode == 0 && $urandom_range(7) == 0) begin
        cfg_window  = CW'($urandom_range(6));
        cfg_holdoff = CW'($urandom_range(6));
        cfg_mask    = NG'($urandom);
      end
      tready  = ($urandom_range(3) != 0);
      aresetn = ($urandom_range(199) != 0);
      r = $urandom_range(9);
      if (r < 6) d = '0;
      else if (r < 8) d = bitv($urandom_range(DW-1));
      else d = {$urandom, $urandom};
      step(d);
    end
    aresetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
